rdc_prec_pipe: RTL

Pipelined, multi-lane precision reducer: converts `LANES` parallel words from `I_CONF` format to `O_CONF` format with selectable rounding, saturation and per-lane underflow/overflow/rounded flags. It also keeps sticky saturation event counters. It sits between wide accumulators and narrow activation/weight storage in the perceptron datapath and takes over from the combinational `rdc_prec` where timing or backpressure is needed.

---
 rtl/rdc_prec_pipe_pkg.sv | 43 ++++
 rtl/rdc_prec_lane.sv | 64 ++++++
 rtl/rdc_prec_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rdc_prec_pipe_pkg.sv
// Shared perceptron datapath types: number formats, rounding modes and
// helpers that give the representable range of a format.
package rdc_prec_pipe_pkg;

   typedef enum logic {FXP, INT} dtype_t;

   typedef enum logic {Disable, Enable} sign_t;

   // A word format: data type, signedness, total bits and fraction bits.
   typedef struct packed {
      dtype_t     dtype;
      sign_t      sign;
      logic [7:0] prec;
      logic [7:0] frac;
   } dconf_t;

   typedef enum logic [1:0] {
      RND_TRUNC   = 2'd0,
      RND_HALF_UP = 2'd1,
      RND_EVEN    = 2'd2
   } rmode_t;

   // Accumulator and activation formats used by the reducer by default.
   localparam dconf_t DCONF_ACC = '{dtype: FXP, sign: Enable, prec: 8'd16, frac: 8'd4};
   localparam dconf_t DCONF_ACT = '{dtype: FXP, sign: Enable, prec: 8'd8,  frac: 8'd3};

   // Largest raw integer representable in format c.
   function automatic longint dconf_max(input dconf_t c);
      if (c.sign == Enable)
         return (longint'(1) << (int'(c.prec) - 1)) - longint'(1);
      else
         return (longint'(1) << int'(c.prec)) - longint'(1);
   endfunction

   // Smallest raw integer representable in format c.
   function automatic longint dconf_min(input dconf_t c);
      if (c.sign == Enable)
         return -(longint'(1) << (int'(c.prec) - 1));
      else
         return longint'(0);
   endfunction

endpackage

// File: rtl/rdc_prec_lane.sv
// One lane of the precision reducer: aligns the binary point to the output
// format and applies the selected rounding. The result is one bit wider than
// the input so a rounding carry is never lost; saturation happens downstream.
module rdc_prec_lane
   import rdc_prec_pipe_pkg::*;
#(
   parameter dconf_t I_CONF = DCONF_ACC,
   parameter dconf_t O_CONF = DCONF_ACT
) (
   input  logic [I_CONF.prec-1:0] i_data,
   input  logic [1:0]             i_rmode,
   output logic [I_CONF.prec:0]   o_inter,
   output logic                   o_rounded
);

   localparam int I_PREC = int'(I_CONF.prec);
   localparam int D      = int'(I_CONF.frac) - int'(O_CONF.frac);
   localparam bit SGN    = (I_CONF.sign == Enable);

   // Input widened by one bit: sign-extended for signed formats, zero otherwise.
   logic [I_PREC:0] w_ext;
   assign w_ext = {SGN & i_data[I_PREC-1], i_data};

   generate
      if (D > 0) begin : g_shr
         logic [I_PREC:0] w_kept;
         logic [D-1:0]    w_disc;
         logic            w_half;
         logic            w_rest;
         logic            w_inc;

         // Floor division by 2^D: the top bit of w_ext already carries the sign.
         assign w_kept = {{D{w_ext[I_PREC]}}, w_ext[I_PREC:D]};
         assign w_disc = w_ext[D-1:0];
         assign w_half = w_disc[D-1];

         if (D > 1) begin : g_rest
            assign w_rest = |w_disc[D-2:0];
         end else begin : g_norest
            assign w_rest = 1'b0;
         end

         // Round-up decision; the unused encoding falls back to truncation.
         // NOTE: every always_comb output gets a default first so no path
         // leaves it unassigned and no latch is inferred.
         always_comb begin
            w_inc = 1'b0;
            case (i_rmode)
               RND_HALF_UP: w_inc = w_half;
               RND_EVEN:    w_inc = w_half & (w_rest | w_kept[0]);
               default:     w_inc = 1'b0;
            endcase
         end

         assign o_inter   = w_kept + {{I_PREC{1'b0}}, w_inc};
         assign o_rounded = |w_disc;
      end else begin : g_shl
         // Output has at least as many fraction bits: exact, never rounded.
         assign o_inter   = w_ext << (-D);
         assign o_rounded = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/rdc_prec_pipe.sv
// Two-stage, fully stallable multi-lane precision reducer. S1 holds the
// rounded intermediate per lane, S2 holds the saturated result and flags.
// Sticky-saturating counters track output beats that overflowed/underflowed.
module rdc_prec_pipe
   import rdc_prec_pipe_pkg::*;
#(
   parameter dconf_t I_CONF = DCONF_ACC,
   parameter dconf_t O_CONF = DCONF_ACT,
   parameter int     LANES  = 4,
   parameter int     CNT_W  = 16
) (
   input  logic                          clk,
   input  logic                          reset_,
   input  logic [1:0]                    rmode,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*I_CONF.prec-1:0]  in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*O_CONF.prec-1:0]  out,
   output logic [LANES-1:0]              udf,
   output logic [LANES-1:0]              ovf,
   output logic [LANES-1:0]              rounded,
   input  logic                          clr_cnt,
   output logic [CNT_W-1:0]              ovf_cnt,
   output logic [CNT_W-1:0]              udf_cnt
);

   localparam int     I_PREC = int'(I_CONF.prec);
   localparam int     O_PREC = int'(O_CONF.prec);
   localparam bit     SGN    = (I_CONF.sign == Enable);
   localparam longint O_MAX  = dconf_max(O_CONF);
   localparam longint O_MIN  = dconf_min(O_CONF);

   // Lane outputs (combinational from the input bus)
   logic [LANES-1:0][I_PREC:0]   w_inter;
   logic [LANES-1:0]             w_rnd;

   // Stage 1
   logic                         r_s1_valid;
   logic [LANES-1:0][I_PREC:0]   r_s1_val;
   logic [LANES-1:0]             r_s1_rnd;

   // Saturation (combinational from stage 1)
   logic [LANES-1:0][O_PREC-1:0] w_sat;
   logic [LANES-1:0]             w_ovf;
   logic [LANES-1:0]             w_udf;

   // Stage 2
   logic                         r_s2_valid;
   logic [LANES-1:0][O_PREC-1:0] r_out;
   logic [LANES-1:0]             r_ovf;
   logic [LANES-1:0]             r_udf;
   logic [LANES-1:0]             r_rnd;

   // Handshake and counters
   logic                         w_s1_en;
   logic                         w_s2_en;
   logic                         w_out_hs;
   logic [CNT_W-1:0]             r_ovf_cnt;
   logic [CNT_W-1:0]             r_udf_cnt;

   genvar g;
   generate
      for (g = 0; g < LANES; g++) begin : g_lane
         rdc_prec_lane #(
            .I_CONF (I_CONF),
            .O_CONF (O_CONF)
         ) u_lane (
            .i_data    (in[g*I_PREC +: I_PREC]),
            .i_rmode   (rmode),
            .o_inter   (w_inter[g]),
            .o_rounded (w_rnd[g])
         );
      end
   endgenerate

   // A stage may load when it is empty or the stage after it is draining,
   // so bubbles collapse and the pipe only stops when both stages are full.
   assign w_s2_en  = ~r_s2_valid | out_ready;
   assign w_s1_en  = ~r_s1_valid | w_s2_en;
   assign in_ready = w_s1_en;
   assign w_out_hs = r_s2_valid & out_ready;

   // Stage 1: capture the rounded intermediate of an accepted beat.
   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_s1_valid <= 1'b0;
         r_s1_val   <= '0;
         r_s1_rnd   <= '0;
      end else if (w_s1_en) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_val <= w_inter;
            r_s1_rnd <= w_rnd;
         end
      end
   end

   // Clamp each lane's intermediate to the output range and flag the clamp.
   always_comb begin : sat_comb
      longint w_val;
      w_sat = '0;
      w_ovf = '0;
      w_udf = '0;
      for (int i = 0; i < LANES; i++) begin
         w_val = SGN ? longint'($signed(r_s1_val[i])) : longint'(r_s1_val[i]);
         if (w_val > O_MAX) begin
            w_sat[i] = O_MAX[O_PREC-1:0];
            w_ovf[i] = 1'b1;
         end else if (w_val < O_MIN) begin
            w_sat[i] = O_MIN[O_PREC-1:0];
            w_udf[i] = 1'b1;
         end else begin
            w_sat[i] = w_val[O_PREC-1:0];
         end
      end
   end

   // Stage 2: register the saturated result; holds while downstream stalls.
   // NOTE: data registers are reset along with the valids so out and the
   // flags read 0 after reset rather than stale values.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_s2_valid <= 1'b0;
         r_out      <= '0;
         r_ovf      <= '0;
         r_udf      <= '0;
         r_rnd      <= '0;
      end else if (w_s2_en) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out <= w_sat;
            r_ovf <= w_ovf;
            r_udf <= w_udf;
            r_rnd <= r_s1_rnd;
         end
      end
   end

   // Count delivered beats with any overflowing lane; clear beats increment.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_ovf_cnt <= '0;
      end else if (clr_cnt) begin
         r_ovf_cnt <= '0;
      end else if (w_out_hs && (|r_ovf) && !(&r_ovf_cnt)) begin
         r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      end
   end

   // Count delivered beats with any underflowing lane; clear beats increment.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_udf_cnt <= '0;
      end else if (clr_cnt) begin
         r_udf_cnt <= '0;
      end else if (w_out_hs && (|r_udf) && !(&r_udf_cnt)) begin
         r_udf_cnt <= r_udf_cnt + CNT_W'(1);
      end
   end

   assign out_valid = r_s2_valid;
   assign out       = r_out;
   assign ovf       = r_ovf;
   assign udf       = r_udf;
   assign rounded   = r_rnd;
   assign ovf_cnt   = r_ovf_cnt;
   assign udf_cnt   = r_udf_cnt;

endmodule
